pipe_mem_arbiter: RTL and testbench
===================================

# pipe_mem_arbiter

Arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port. It issues each access for a fixed latency and returns a registered acknowledge. It also drives a combined stall to the hazard unit and keeps saturating stall-cycle counters per port. It sits between the CPU's IF/MEM stages and the backing memory array.

## Interface
- MEM_LAT, 2, memory access latency in cycles (1..15)
- AW, 32, address width
- DW, 32, data width
- CNT_W, 16, stall counter width

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  AW  fetch address
- if_kill_i  in  1  flush: cancel pending or in-flight fetch
- if_ack_o  out  1  one-cycle fetch-complete pulse
- if_data_o  out  DW  fetched word, valid with if_ack_o, held afterwards
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = write
- dm_addr_i  in  AW  data address
- dm_wdata_i  in  DW  write data
- dm_ack_o  out  1  one-cycle data-complete pulse
- dm_rdata_o  out  DW  read data, valid with dm_ack_o on reads; unchanged on writes
- mem_en_o  out  1  memory access active
- mem_we_o  out  1  memory write enable (qualified by mem_en_o)
- mem_addr_o  out  AW  latched access address
- mem_wdata_o  out  DW  latched write data
- mem_rdata_i  in  DW  memory read data, valid in last access cycle
- stall_o  out  1  (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational
- if_wait_cnt_o  out  CNT_W  saturating count of IF stall cycles
- dm_wait_cnt_o  out  CNT_W  saturating count of DM stall cycles

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE grant rules:
  - A port is eligible if its req is high and its ack_o is low this cycle.
  - IF is additionally ineligible while if_kill_i is high.
  - Only one port eligible: grant it.
  - Both eligible: grant the port not served last. The last-served flag resets to IF, so DM wins the first tie.
- On grant:
  - Latch address, we and wdata; we and wdata are 0 for IF.
  - Load cnt <= MEM_LAT and move to BUSY_x.
- BUSY_x:
  - mem_en_o = 1 with the latched command; cnt decrements each cycle.
  - On the cycle with cnt == 1: capture mem_rdata_i for reads, return to IDLE, pulse the owning ack_o next cycle, and update last-served.
- Kill handling:
  - if_kill_i high in any BUSY_IF cycle sets a kill flag.
  - The access completes with no if_ack_o and if_data_o unchanged.
  - The kill flag clears on return to IDLE.
- The requester dropping req mid-access does not abort it; ack is still pulsed.
- Counters: x_wait_cnt increments each cycle (x_req_i & ~x_ack_o) and saturates at 2^CNT_W-1.
- Reset: state IDLE, all outputs 0, counters 0, kill flag 0, last-served IF. Any in-flight access is abandoned with no ack after release.

## Timing
- Request at cycle t with the arbiter in IDLE: mem_en_o high t+1..t+MEM_LAT, ack at t+MEM_LAT+1. Latency is MEM_LAT+1.
- The ack cycle is an IDLE cycle; a new grant can occur in it, giving back-to-back accesses with no gap.
- Both ports continuously requesting: grants alternate, throughput one access per MEM_LAT+1 cycles.
- stall_o has zero-cycle response; every other output is registered.

## Structure
- Package pipe_mem_pkg holds the state enum {IDLE, BUSY_IF, BUSY_DM}, the port-select encoding, and the MEM_LAT bound check (1..15, 4-bit cnt).
- Sub-module sat_counter (parameter CNT_W; ports inc, value), instantiated twice.

## Test plan
- IF only, MEM_LAT=2: if_req at cycle 0, addr 0x8, mem_rdata_i=0x20080005 -> mem_en_o cycles 1–2, if_ack_o at cycle 3 with data 0x20080005, stall_o high cycles 0–2, if_wait_cnt=3.
- Simultaneous after reset: DM write addr 0x4 data 0x7 plus IF req -> DM granted first (mem_we_o=1 cycles 1–2), dm_ack_o at 3, IF granted at 3, if_ack_o at 6, if_wait_cnt=6.
- Both held continuously for 12 cycles -> grant order DM, IF, DM, IF; acks at cycles 3, 6, 9, 12.
- if_kill_i pulsed at cycle 1 of BUSY_IF -> no if_ack_o, IDLE after completion; re-request is served normally with if_ack_o MEM_LAT+1 later.
- rst_i low during BUSY_DM -> mem_en_o, acks and counters 0 immediately; no dm_ack_o after release; next request starts a fresh grant.
- if_req_i and if_kill_i held high for 70000 cycles -> no IF grant, if_wait_cnt_o saturates at 65535 and stays.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared types for the unified-memory arbiter.
//   state_t    : arbiter FSM states
//   port_t     : port-select / last-served encoding
//   LAT_W      : width of the access-latency down-counter
//   mem_lat_ok : legal range check for the MEM_LAT parameter
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

  localparam int LAT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_sat_counter.sv
// Saturating up-counter used for the per-port stall statistics.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset, clears value
//   inc   : count this cycle
//   value : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      value <= '0;
    end else if (inc && (value != CNT_MAX)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF)
// and data memory (DM). Each grant drives the memory for MEM_LAT cycles and
// returns a registered one-cycle acknowledge.
//   clk_i, rst_i              : clock, async active-low reset
//   if_req/addr/kill, if_ack/data       : fetch port
//   dm_req/we/addr/wdata, dm_ack/rdata  : data port
//   mem_en/we/addr/wdata, mem_rdata     : memory side
//   stall_o                   : combinational stall to the hazard unit
//   if_wait_cnt_o/dm_wait_cnt_o : saturating stall-cycle counters
//   dbg_state_o               : current FSM state for observation
//
// Handshake: a requester raises x_req_i with stable command fields and holds
// it until x_ack_o pulses; the ack is a single-cycle pulse one cycle after
// the last memory cycle. During the ack cycle the port is not eligible for a
// new grant, so a held req is not served twice. Dropping req mid-access does
// not abort it; if_kill_i suppresses the fetch ack and data update instead.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [AW-1:0]    if_addr_i,
  input  logic             if_kill_i,
  output logic             if_ack_o,
  output logic [DW-1:0]    if_data_o,
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [AW-1:0]    dm_addr_i,
  input  logic [DW-1:0]    dm_wdata_i,
  output logic             dm_ack_o,
  output logic [DW-1:0]    dm_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] if_wait_cnt_o,
  output logic [CNT_W-1:0] dm_wait_cnt_o,
  output logic [1:0]       dbg_state_o
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("pipe_mem_arbiter: MEM_LAT must be within 1..15");
  end

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  port_t             last_q, last_d;
  logic              kill_q, kill_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DW-1:0]     if_data_q, if_data_d;
  logic [DW-1:0]     dm_rdata_q, dm_rdata_d;

  logic if_elig, dm_elig, grant_if, grant_dm;

  // A port is not eligible in its own ack cycle; a flushing fetch never is.
  assign if_elig = if_req_i & ~if_ack_q & ~if_kill_i;
  assign dm_elig = dm_req_i & ~dm_ack_q;

  // On a tie the port not served last wins (last_q resets to IF, so DM first).
  assign grant_dm = dm_elig & (~if_elig | (last_q == PORT_IF));
  assign grant_if = if_elig & ~grant_dm;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= PORT_IF;
      kill_q     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      kill_q     <= kill_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    kill_d     = kill_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d = BUSY_DM;
          cnt_d   = LAT_W'(MEM_LAT);
          addr_d  = dm_addr_i;
          we_d    = dm_we_i;
          wdata_d = dm_wdata_i;
        end else if (grant_if) begin
          state_d = BUSY_IF;
          cnt_d   = LAT_W'(MEM_LAT);
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        cnt_d = cnt_q - LAT_W'(1);
        if ((state_q == BUSY_IF) && if_kill_i) begin
          kill_d = 1'b1;
        end
        if (cnt_q == LAT_W'(1)) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (state_q == BUSY_IF) begin
            last_d = PORT_IF;
            // A kill seen in any busy cycle, including this last one, drops the fetch.
            if (!(kill_q || if_kill_i)) begin
              if_ack_d  = 1'b1;
              if_data_d = mem_rdata_i;
            end
          end else begin
            last_d   = PORT_DM;
            dm_ack_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = (state_q != IDLE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign dbg_state_o = state_q;

  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

  sat_counter #(.CNT_W(CNT_W)) u_if_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (if_req_i & ~if_ack_q),
    .value (if_wait_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dm_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (dm_req_i & ~dm_ack_q),
    .value (dm_wait_cnt_o)
  );

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios plus random
// traffic, all checked against a cycle-numbered transaction model.
module tb_pipe_mem_arbiter;

  localparam int MEM_LAT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CNT_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             if_req_i = 1'b0;
  logic [AW-1:0]    if_addr_i = '0;
  logic             if_kill_i = 1'b0;
  logic             if_ack_o;
  logic [DW-1:0]    if_data_o;
  logic             dm_req_i = 1'b0;
  logic             dm_we_i = 1'b0;
  logic [AW-1:0]    dm_addr_i = '0;
  logic [DW-1:0]    dm_wdata_i = '0;
  logic             dm_ack_o;
  logic [DW-1:0]    dm_rdata_o;
  logic             mem_en_o;
  logic             mem_we_o;
  logic [AW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic [DW-1:0]    mem_rdata_i = '0;
  logic             stall_o;
  logic [CNT_W-1:0] if_wait_cnt_o;
  logic [CNT_W-1:0] dm_wait_cnt_o;
  logic [1:0]       dbg_state_o;

  pipe_mem_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_kill_i     (if_kill_i),
    .if_ack_o      (if_ack_o),
    .if_data_o     (if_data_o),
    .dm_req_i      (dm_req_i),
    .dm_we_i       (dm_we_i),
    .dm_addr_i     (dm_addr_i),
    .dm_wdata_i    (dm_wdata_i),
    .dm_ack_o      (dm_ack_o),
    .dm_rdata_o    (dm_rdata_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .stall_o       (stall_o),
    .if_wait_cnt_o (if_wait_cnt_o),
    .dm_wait_cnt_o (dm_wait_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // An access granted in cycle g occupies the memory in cycles g+1..g+MEM_LAT
  // and is acknowledged in cycle g+MEM_LAT+1.
  int            m_owner;   // 0 none, 1 IF, 2 DM
  int            m_end;     // last memory cycle of the current access
  bit            m_killed;
  bit            m_last_dm;
  logic          m_if_ack, m_dm_ack;
  logic [DW-1:0] m_if_data, m_dm_data;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            m_if_cnt, m_dm_cnt;

  task automatic model_reset();
    m_owner = 0; m_end = 0; m_killed = 0; m_last_dm = 0;
    m_if_ack = 0; m_dm_ack = 0; m_if_data = '0; m_dm_data = '0;
    m_addr = '0; m_we = 0; m_wdata = '0; m_if_cnt = 0; m_dm_cnt = 0;
  endtask

  task automatic model_advance();
    logic n_if_ack, n_dm_ack;
    bit ife, dme, pick_dm;
    n_if_ack = 0;
    n_dm_ack = 0;
    if (if_req_i && !m_if_ack) m_if_cnt = (m_if_cnt >= CMAX) ? CMAX : m_if_cnt + 1;
    if (dm_req_i && !m_dm_ack) m_dm_cnt = (m_dm_cnt >= CMAX) ? CMAX : m_dm_cnt + 1;
    if (m_owner != 0) begin
      if (m_owner == 1 && if_kill_i) m_killed = 1;
      if (cyc == m_end) begin
        if (m_owner == 1) begin
          if (!m_killed) begin
            n_if_ack  = 1;
            m_if_data = mem_rdata_i;
          end
          m_last_dm = 0;
        end else begin
          n_dm_ack = 1;
          if (!m_we) m_dm_data = mem_rdata_i;
          m_last_dm = 1;
        end
        m_owner  = 0;
        m_killed = 0;
      end
    end else begin
      ife = if_req_i && !m_if_ack && !if_kill_i;
      dme = dm_req_i && !m_dm_ack;
      if (ife || dme) begin
        pick_dm = dme && (!ife || !m_last_dm);
        m_owner = pick_dm ? 2 : 1;
        m_end   = cyc + MEM_LAT;
        m_addr  = pick_dm ? dm_addr_i : if_addr_i;
        m_we    = pick_dm && dm_we_i;
        m_wdata = pick_dm ? dm_wdata_i : '0;
      end
    end
    m_if_ack = n_if_ack;
    m_dm_ack = n_dm_ack;
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- per-cycle driver / monitor ----------------
  bit            rd_fixed_en = 0;
  logic [DW-1:0] rd_fixed = '0;
  logic [31:0]   en_mask, stall_mask, we_mask;
  int            if_acks[$];
  int            dm_acks[$];
  int            en_cnt;
  logic          seen_if_ack, seen_dm_ack;

  task automatic start_test();
    t0 = cyc;
    en_mask = '0; stall_mask = '0; we_mask = '0;
    if_acks.delete(); dm_acks.delete();
    en_cnt = 0;
  endtask

  task automatic compare_outputs();
    check("stall", stall_o, (if_req_i & ~m_if_ack) | (dm_req_i & ~m_dm_ack));
    check("mem_en", mem_en_o, m_owner != 0);
    if (m_owner != 0) begin
      check("mem_addr", mem_addr_o, m_addr);
      check("mem_we", mem_we_o, m_we);
      check("mem_wdata", mem_wdata_o, m_wdata);
    end
    check("if_ack", if_ack_o, m_if_ack);
    check("dm_ack", dm_ack_o, m_dm_ack);
    check("if_data", if_data_o, m_if_data);
    check("dm_rdata", dm_rdata_o, m_dm_data);
    check("if_wait_cnt", if_wait_cnt_o, m_if_cnt);
    check("dm_wait_cnt", dm_wait_cnt_o, m_dm_cnt);
  endtask

  // Inputs for the current cycle are already driven; sample at the falling edge.
  task automatic tick();
    int rel;
    @(negedge clk_i);
    if (m_owner != 0 && cyc == m_end) mem_rdata_i = rd_fixed_en ? rd_fixed : mem_word(m_addr);
    else mem_rdata_i = $urandom;
    compare_outputs();
    rel = cyc - t0;
    if (rel >= 0 && rel < 32) begin
      if (mem_en_o) en_mask[rel] = 1'b1;
      if (stall_o) stall_mask[rel] = 1'b1;
      if (mem_en_o && mem_we_o) we_mask[rel] = 1'b1;
    end
    if (if_ack_o) if_acks.push_back(rel);
    if (dm_ack_o) dm_acks.push_back(rel);
    if (mem_en_o) en_cnt++;
    seen_if_ack = m_if_ack;
    seen_dm_ack = m_dm_ack;
    model_advance();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    if_req_i = 0; if_kill_i = 0; dm_req_i = 0; dm_we_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_if();
    if_req_i  = 1'b1;
    if_addr_i = $urandom;
  endtask

  task automatic new_dm();
    dm_req_i   = 1'b1;
    dm_we_i    = $urandom_range(0, 1);
    dm_addr_i  = $urandom;
    dm_wdata_i = $urandom;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    #2;
    check("rst_mem_en", mem_en_o, 0);
    check("rst_acks", {if_ack_o, dm_ack_o}, 0);
    check("rst_cnts", {if_wait_cnt_o, dm_wait_cnt_o}, 0);
    check("rst_data", {if_data_o, dm_rdata_o}, 0);
    do_reset();

    // IF only: fetch of 0x8 returning 0x20080005.
    start_test();
    rd_fixed_en = 1; rd_fixed = 32'h2008_0005;
    if_addr_i = 32'h8;
    for (int i = 0; i < 6; i++) begin
      if_req_i = (i <= 3);
      tick();
    end
    rd_fixed_en = 0;
    check("t1_en_cycles", en_mask[5:0], 6'b000110);
    check("t1_stall_cycles", stall_mask[5:0], 6'b000111);
    check("t1_if_ack_cycle", q_at(if_acks, 0), 3);
    check("t1_if_ack_count", if_acks.size(), 1);
    check("t1_if_data", if_data_o, 32'h2008_0005);
    check("t1_if_wait_cnt", if_wait_cnt_o, 3);

    // Simultaneous after reset: DM write wins the first tie.
    do_reset();
    start_test();
    if_addr_i = 32'h8; dm_addr_i = 32'h4; dm_wdata_i = 32'h7; dm_we_i = 1;
    for (int i = 0; i < 8; i++) begin
      dm_req_i = (i <= 3);
      if_req_i = (i <= 6);
      tick();
    end
    check("t2_we_cycles", we_mask[7:0], 8'b0000_0110);
    check("t2_dm_ack_cycle", q_at(dm_acks, 0), 3);
    check("t2_if_ack_cycle", q_at(if_acks, 0), 6);
    check("t2_if_wait_cnt", if_wait_cnt_o, 6);

    // Both held: grants alternate DM, IF, DM, IF.
    do_reset();
    start_test();
    if_addr_i = 32'h100; dm_addr_i = 32'h200; dm_we_i = 0;
    for (int i = 0; i < 13; i++) begin
      if_req_i = 1; dm_req_i = 1;
      tick();
    end
    check("t3_dm_ack0", q_at(dm_acks, 0), 3);
    check("t3_if_ack0", q_at(if_acks, 0), 6);
    check("t3_dm_ack1", q_at(dm_acks, 1), 9);
    check("t3_if_ack1", q_at(if_acks, 1), 12);

    // Kill during BUSY_IF: no ack, then normal re-grant.
    do_reset();
    start_test();
    if_addr_i = 32'h40;
    for (int i = 0; i < 7; i++) begin
      if_req_i  = 1;
      if_kill_i = (i == 1);
      tick();
    end
    if_kill_i = 0;
    check("t4_en_cycles", en_mask[6:0], 7'b011_0110);
    check("t4_if_ack_cycle", q_at(if_acks, 0), 6);
    check("t4_if_ack_count", if_acks.size(), 1);

    // Reset while BUSY_DM.
    do_reset();
    start_test();
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h80;
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    check("t5_rst_mem_en", mem_en_o, 0);
    check("t5_rst_acks", {if_ack_o, dm_ack_o}, 0);
    check("t5_rst_dm_cnt", dm_wait_cnt_o, 0);
    dm_req_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    start_test();
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_stale_ack", dm_acks.size(), 0);
    start_test();
    dm_addr_i = 32'hC0;
    for (int i = 0; i < 5; i++) begin
      dm_req_i = (i <= 3);
      tick();
    end
    check("t5_fresh_ack_cycle", q_at(dm_acks, 0), MEM_LAT + 1);
    check("t5_fresh_rdata", dm_rdata_o, mem_word(32'hC0));

    // Random traffic against the model.
    do_reset();
    start_test();
    seen_if_ack = 0; seen_dm_ack = 0;
    for (int i = 0; i < 4000; i++) begin
      if_kill_i = ($urandom_range(0, 19) == 0);
      if (if_req_i) begin
        if (seen_if_ack || if_kill_i) begin
          if ($urandom_range(0, 1) == 1) new_if(); else if_req_i = 0;
        end else if ($urandom_range(0, 49) == 0) begin
          if_req_i = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        new_if();
      end
      if (dm_req_i) begin
        if (seen_dm_ack) begin
          if ($urandom_range(0, 1) == 1) new_dm(); else dm_req_i = 0;
        end else if ($urandom_range(0, 49) == 0) begin
          dm_req_i = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        new_dm();
      end
      tick();
    end

    // Fetch held under kill: never granted, counter saturates and sticks.
    do_reset();
    start_test();
    if_req_i = 1; if_kill_i = 1; if_addr_i = 32'h1000;
    for (int i = 0; i < 70000; i++) tick();
    check("t6_no_grant", en_cnt, 0);
    check("t6_if_wait_sat", if_wait_cnt_o, CMAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
